// File: rtl/wide_add_seq.sv
// Multi-word adder: adds WORDS x N-bit operands one N-bit word per clock, LSW first.
// Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN.

module fulladder #(
  parameter int N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] total;

  // Plain N-bit ripple add; the carry out is the extra top bit.
  always_comb begin
    total = {1'b0, in1} + {1'b0, in2} + {{N{1'b0}}, cin};
  end

  assign sum  = total[N-1:0];
  assign cout = total[N];

endmodule

module wide_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               cout
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          accept;
  logic          load_carry;

  logic [N-1:0]  add_in1;
  logic [N-1:0]  add_in2;
  logic [N-1:0]  add_sum;
  logic          add_cout;

`ifdef WIDE_ADD_SUB_EN
  logic sub_reg;
`endif

  assign accept = start && (state == IDLE || state == DONE);

  // Select the current operand word; in subtract mode feed the inverted b word.
  always_comb begin
    add_in1 = a_reg[int'(idx)*N +: N];
`ifdef WIDE_ADD_SUB_EN
    add_in2 = sub_reg ? ~b_reg[int'(idx)*N +: N]
                      : b_reg[int'(idx)*N +: N];
    load_carry = sub ? 1'b1 : cin;
`else
    add_in2 = b_reg[int'(idx)*N +: N];
    load_carry = cin;
`endif
  end

  fulladder #(.N(N)) u_add (
    .in1  (add_in1),
    .in2  (add_in2),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Sequencer: operand capture, per-word accumulate, registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_reg <= a;
        b_reg <= b;
        carry <= load_carry;
        idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
        sub_reg <= sub;
`endif
      end
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sum[int'(idx)*N +: N] <= add_sum;
          carry <= add_cout;
          if (idx == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= add_cout;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized self-checking bench for wide_add_seq (N=8, WORDS=4).
// Reference results come from whole-word arithmetic on 33-bit values.

module tb_wide_add_seq;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef WIDE_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk  = 0;
  int n_fail = 0;

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef WIDE_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from acceptance to done, checked against whole-word math.
  task automatic do_op(input string tag, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tc,
                       input logic ts);
    logic [W:0] ref_v;
    int  k;
    int  nbusy;
    bit  seen;
    bit  overlap;
    if (ts) ref_v = {(ta >= tb), ta - tb};
    else    ref_v = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    a     = ta;
    b     = tb;
    cin   = tc;
`ifdef WIDE_ADD_SUB_EN
    sub   = ts;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    cin   = 1'($urandom);
`ifdef WIDE_ADD_SUB_EN
    sub   = 1'($urandom);
`endif
    seen    = 0;
    overlap = 0;
    nbusy   = 0;
    k       = 0;
    while (!seen && k < 20) begin
      if (busy && done) overlap = 1;
      if (done) begin
        seen = 1;
      end else begin
        if (busy) nbusy++;
        tick();
        k++;
      end
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_lat"}, 64'(k), 64'(WORDS));
    chk({tag, "_busy"}, 64'(nbusy), 64'(WORDS));
    chk({tag, "_ovl"}, 64'(overlap), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'(ref_v[W-1:0]));
    chk({tag, "_cout"}, 64'(cout), 64'(ref_v[W]));
  endtask

  initial begin
    int ndone;
    int last;
    int cyc;
    bit got_done;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub   = 1'b0;
`endif
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    tick();

    do_op("carry_w0", 32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    tick();
    do_op("ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    do_op("b2b", 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    tick();

    // start during RUN must be ignored
    a     = 32'h12345678;
    b     = 32'h11111111;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int s = 0; s < 12; s++) begin
      if (s == 0) begin
        start = 1'b1;
        a     = '0;
        b     = '0;
      end
      if (s == 2) start = 1'b0;
      if (done) begin
        ndone++;
        chk("ign_sum", 64'(sum), 64'h23456789);
        chk("ign_cout", 64'(cout), 64'd0);
      end
      tick();
    end
    chk("ign_pulses", 64'(ndone), 64'd1);

    // reset in the second RUN cycle aborts
    a     = 32'hDEADBEEF;
    b     = 32'h01010101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    got_done = 0;
    for (int s = 0; s < 8; s++) begin
      if (done) got_done = 1;
      tick();
    end
    chk("abort_nodone", 64'(got_done), 64'd0);
    do_op("after_rst", 32'h00C0FFEE, 32'h00001234, 1'b1, 1'b0);
    tick();
    tick();

    // start held high: one result every WORDS+1 cycles
    a     = 32'd1;
    b     = 32'd2;
    cin   = 1'b0;
    start = 1'b1;
    ndone = 0;
    last  = 0;
    cyc   = 0;
    while (ndone < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (done) begin
        chk("stream_sum", 64'(sum), 64'd3);
        if (ndone > 0) chk("stream_gap", 64'(cyc - last), 64'(WORDS + 1));
        last = cyc;
        ndone++;
        tick();
        cyc++;
        chk("stream_busy", 64'(busy), 64'd1);
      end
    end
    chk("stream_cnt", 64'(ndone), 64'd4);
    start = 1'b0;
    for (int s = 0; s < 8; s++) tick();

`ifdef WIDE_ADD_SUB_EN
    do_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1);
    do_op("sub_pos", 32'd7, 32'd5, 1'b1, 1'b1);
    tick();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ~ra;
      rs = 1'b0;
`ifdef WIDE_ADD_SUB_EN
      rs = 1'($urandom);
`endif
      do_op("rand", ra, rb, 1'($urandom), rs);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-word addition sequencer that drives the team's N-bit `fulladder` to add two WORDS×N-bit operands, one N-bit word per clock, least-significant word first. The carry is held in a register between words. It sits between a requester that supplies wide operands with a start pulse and a single shared `fulladder #(.N(N))` instance inside the block. It trades latency for adder area when operands are wider than the datapath adder.

## Interface
- `N`, default 8: adder word width, passed to the internal `fulladder`.
- `WORDS`, default 4: number of words per operand; legal range ≥1.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only when the block can accept.
- `a` in N*WORDS: operand 1, captured at acceptance.
- `b` in N*WORDS: operand 2, captured at acceptance.
- `cin` in 1: carry into word 0, captured at acceptance.
- `sub` in 1: subtract select; port exists only with `WIDE_ADD_SUB_EN`.
- `busy` out 1: high while words are being processed.
- `done` out 1: one-cycle pulse; `sum` and `cout` are valid in that cycle.
- `sum` out N*WORDS: result register.
- `cout` out 1: carry out of the most significant word.

## Operation
- FSM states:
  - IDLE: start accepted → RUN.
  - RUN: WORDS cycles, then → DONE.
  - DONE: lasts one cycle; start accepted → RUN, otherwise → IDLE.
- Acceptance, when `start`=1 in IDLE or DONE:
  - capture `a` and `b` into operand registers;
  - load carry register with `cin`;
  - clear word index to 0.
- Each RUN cycle, for word index i:
  - adder in1 = a_reg word i, in2 = b_reg word i, cin = carry register;
  - at the edge: sum_reg word i ← adder sum, carry register ← adder cout, i ← i+1.
- Word index register is max(1, clog2(WORDS)) bits wide. Index wraps to 0 only on a new acceptance, never by overflow.
- Leaving RUN: `cout` ← final carry.
- `sum` and `cout` hold their value from DONE until the next operation starts overwriting words. Individual words of `sum` may change during RUN.
- `start` during RUN is ignored: no queuing, no error.
- `rst`:
  - state ← IDLE, index ← 0, carry ← 0;
  - outputs `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - reset mid-RUN aborts the operation and no `done` is produced.
- Arithmetic: modulo 2^(N*WORDS); `cout` is the true carry out of bit N*WORDS-1.

## Timing
- Start sampled at edge E → `busy`=1 from edge E through edge E+WORDS.
- `done`=1 in the cycle after edge E+WORDS. Total latency is WORDS+1 cycles from acceptance to `done`.
- `busy` and `done` are never high together.
- Back-to-back: `start` high in the DONE cycle gives `busy`=1 in the very next cycle. Throughput is one operation per WORDS+1 cycles.
- WORDS=1: a single RUN cycle; `done` appears 2 cycles after acceptance.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `WIDE_ADD_SUB_EN` defined:
  - `sub` port is present and captured at acceptance.
  - With `sub`=1: adder in2 = bitwise inverse of the b word, and the carry register loads 1 (`cin` ignored). `sum` = a−b mod 2^(N*WORDS); `cout`=1 means no borrow.
  - With `sub`=0: plain addition.
- `WIDE_ADD_SUB_EN` undefined: no `sub` port and no inversion logic; addition only.

## Test plan
All cases use N=8, WORDS=4.
- a=0x000000FF, b=0x00000001, cin=0, start at edge E → `done` in the cycle after E+4; `sum`=0x00000100, `cout`=0; word 0 carry reaches word 1.
- a=0xFFFFFFFF, b=0x00000000, cin=1 → `sum`=0x00000000, `cout`=1; carry ripples through all 4 words.
- Start accepted with a=0x12345678, b=0x11111111, then `start`=1 with a=b=0 during RUN → ignored; `sum`=0x23456789, `cout`=0, exactly one `done` pulse.
- `rst`=1 during the second RUN cycle → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0; no `done` pulse afterwards; a fresh start then completes normally.
- `start` held high continuously with a=1, b=2, cin=0 → `done` every 5 cycles, `busy` high the cycle after each `done`, `sum`=0x00000003 each time.
- With `WIDE_ADD_SUB_EN`:
  - `sub`=1, a=5, b=7 → `sum`=0xFFFFFFFE, `cout`=0;
  - `sub`=1, a=7, b=5 → `sum`=0x00000002, `cout`=1.
